// File: rtl/branch_resolver.sv
// Branch/jump resolver: detects EX-stage mispredicts and drives a redirect + IF/ID flush (optional counters: BR_RESOLVER_STATS_EN).
// Latency: mispredict in EX on cycle N -> redirect_valid on cycle N+1; all outputs registered.
// Backpressure: redirect_pc held stable with EX stalled until redirect_ready; flush then holds FLUSH_CYCLES cycles.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_cond_true,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_jump_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        stall_ex
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] pc_nxt;
    logic        taken;
    logic [31:0] actual_tgt;
    logic        mispredict;
    logic [31:0] correct_pc;

    // Jump targets from JALR may carry bit0 set; it is always dropped.
    assign taken      = ex_is_branch ? ex_cond_true : 1'b1;
    assign actual_tgt = ex_is_branch ? (ex_pc + ex_imm) : {ex_jump_target[31:1], 1'b0};
    assign mispredict = (taken != ex_pred_taken) ||
                        (taken && ex_pred_taken && (actual_tgt != ex_pred_target));
    assign correct_pc = taken ? actual_tgt : (ex_pc + 32'd4);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = redirect_pc;
        case (state)
            IDLE: begin
                if (ex_valid && mispredict) begin
                    state_nxt = REDIRECT;
                    pc_nxt    = correct_pc;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        state_nxt = FLUSH;
                        cnt_nxt   = 3'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                if (cnt <= 3'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            redirect_pc    <= 32'd0;
            redirect_valid <= 1'b0;
            stall_ex       <= 1'b0;
            flush          <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            redirect_pc    <= pc_nxt;
            redirect_valid <= (state_nxt == REDIRECT);
            stall_ex       <= (state_nxt == REDIRECT);
            flush          <= (state_nxt != IDLE);
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (state == IDLE && ex_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed literal scenarios plus randomized traffic against a behavioural model.
module tb_branch_resolver;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_cond_true = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_imm = '0, ex_jump_target = '0, ex_pred_target = '0;
    logic        redirect_valid, redirect_ready = 1'b0, flush, stall_ex;
    logic [31:0] redirect_pc;
`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    branch_resolver #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_cond_true(ex_cond_true),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_jump_target(ex_jump_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush), .stall_ex(stall_ex)
`ifdef BR_RESOLVER_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outcome of one resolved EX instruction.
    function automatic void ref_eval(input logic br, input logic cond, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic [31:0] jt,
                                     input logic pt, input logic [31:0] ptgt,
                                     output logic mis, output logic [31:0] cpc);
        logic        tk;
        logic [31:0] tgt;
        tk  = br ? cond : 1'b1;
        tgt = br ? pc + imm : (jt & 32'hFFFF_FFFE);
        mis = (tk != pt) || (tk && pt && tgt != ptgt);
        cpc = tk ? tgt : pc + 32'd4;
    endfunction

    // Model: an outstanding redirect, and the number of flush-only cycles still owed.
    bit          m_pending;
    int          m_flush_left;
    logic [31:0] m_pc;
    logic [31:0] m_br, m_mis;

    always @(posedge clk or posedge rst) begin
        logic        mis;
        logic [31:0] cpc;
        if (rst) begin
            m_pending = 0; m_flush_left = 0; m_pc = 0; m_br = 0; m_mis = 0;
        end else if (m_pending) begin
            if (redirect_ready) begin
                m_pending    = 0;
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (ex_valid) begin
            m_br++;
            ref_eval(ex_is_branch, ex_cond_true, ex_pc, ex_imm, ex_jump_target,
                     ex_pred_taken, ex_pred_target, mis, cpc);
            if (mis) begin
                m_pending = 1;
                m_pc      = cpc;
                m_mis++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("redirect_valid", 32'(redirect_valid), 32'(m_pending));
        check("stall_ex", 32'(stall_ex), 32'(m_pending));
        check("flush", 32'(flush), 32'(m_pending || m_flush_left > 0));
        check("redirect_pc", redirect_pc, m_pc);
`ifdef BR_RESOLVER_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    end

    task automatic drive(input logic v, input logic br, input logic cond, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] jt, input logic pt,
                         input logic [31:0] ptgt, input logic rdy);
        @(negedge clk);
        ex_valid = v; ex_is_branch = br; ex_cond_true = cond; ex_pc = pc; ex_imm = imm;
        ex_jump_target = jt; ex_pred_taken = pt; ex_pred_target = ptgt; redirect_ready = rdy;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic quiesce(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic fl, input logic st,
                              input logic [31:0] pc);
        check({tag, ".rv"}, 32'(redirect_valid), 32'(rv));
        check({tag, ".flush"}, 32'(flush), 32'(fl));
        check({tag, ".stall"}, 32'(stall_ex), 32'(st));
        check({tag, ".pc"}, redirect_pc, pc);
    endtask

    initial begin
        #2;
        expect_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Correctly predicted taken backward branch.
        drive(1, 1, 1, 32'h1000, 32'hFFFF_FFE0, 0, 1, 32'h0FE0, 0);
        after_edge();
        expect_out("pred_ok", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        check("pred_ok.flush2", 32'(flush), 0);

        // Predicted taken, actually not taken.
        drive(1, 1, 0, 32'h1000, 32'hFFFF_FFE0, 0, 1, 32'h0FE0, 0);
        after_edge();
        expect_out("nt_mis", 1, 1, 1, 32'h1004);
        quiesce(6);

        // Predicted not taken, actually taken; accepted on first cycle.
        drive(1, 1, 1, 32'h1000, 32'd16, 0, 0, 0, 0);
        after_edge();
        expect_out("tk_mis", 1, 1, 1, 32'h1010);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        after_edge();
        expect_out("tk_f1", 0, 1, 0, 32'h1010);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        expect_out("tk_f2", 0, 1, 0, 32'h1010);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        expect_out("tk_idle", 0, 0, 0, 32'h1010);

        // Jump with odd target, wrong predicted target, fetch stalls 3 cycles.
        drive(1, 0, 0, 32'h1800, 0, 32'h2001, 1, 32'h3000, 0);
        after_edge();
        expect_out("jmp", 1, 1, 1, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h4000, 32'd8, 0, 1, 32'h4008, 0);
            after_edge();
            expect_out($sformatf("jmp_hold%0d", i), 1, 1, 1, 32'h2000);
        end
        drive(1, 1, 0, 32'h4000, 32'd8, 0, 1, 32'h4008, 1);
        after_edge();
        expect_out("jmp_f1", 0, 1, 0, 32'h2000);
        drive(1, 1, 0, 32'h4000, 32'd8, 0, 1, 32'h4008, 1);
        after_edge();
        expect_out("jmp_f2", 0, 1, 0, 32'h2000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        expect_out("jmp_idle", 0, 0, 0, 32'h2000);

        // Reset while a redirect is pending.
        drive(1, 1, 1, 32'h5000, 32'd64, 0, 0, 0, 0);
        after_edge();
        expect_out("pre_rst", 1, 1, 1, 32'h5040);
        @(negedge clk);
        ex_valid = 0; redirect_ready = 0;
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            after_edge();
            check("post_rst.rv", 32'(redirect_valid), 0);
        end

        // Three branches, one mispredicted, counted from reset.
        drive(1, 1, 1, 32'h100, 32'd8, 0, 1, 32'h108, 0);
        drive(1, 1, 0, 32'h200, 32'd8, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h300, 32'd8, 0, 0, 0, 0);
        after_edge();
        quiesce(4);
`ifdef BR_RESOLVER_STATS_EN
        after_edge();
        check("stat_branches_lit", stat_branches, 3);
        check("stat_mispredicts_lit", stat_mispredicts, 1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            logic        br, cond, pt, mis;
            logic [31:0] pc, imm, jt, ptgt, cpc;
            br   = 1'($urandom);
            cond = 1'($urandom);
            pt   = 1'($urandom);
            pc   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFFC;
            imm  = 32'($signed($urandom_range(0, 2047)) - 1024);
            jt   = $urandom;
            ref_eval(br, cond, pc, imm, jt, 1'b1, 32'h0, mis, cpc);
            ptgt = ($urandom_range(0, 3) != 0) ? cpc : $urandom;
            drive(1'($urandom_range(0, 9) < 6), br, cond, pc, imm, jt, pt, ptgt,
                  1'($urandom_range(0, 9) < 5));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 expect_out("rand_rst", 0, 0, 0, 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        quiesce(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a redirect is accepted (range 0..7).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ex_valid  input  1  branch or jump present in EX this cycle.
REQ-005 SHALL have port ex_is_branch  input  1  1 = conditional branch, 0 = unconditional jump (JAL/JALR).
REQ-006 SHALL have port ex_cond_true  input  1  branch condition result from ALU; ignored for jumps.
REQ-007 SHALL have port ex_pc  input  32  PC of the EX instruction.
REQ-008 SHALL have port ex_imm  input  32  signed branch offset, sign-extended.
REQ-009 SHALL have port ex_jump_target  input  32  ALU-computed jump target; used only when ex_is_branch=0.
REQ-010 SHALL have port ex_pred_taken  input  1  fetch-stage prediction carried down the pipe.
REQ-011 SHALL have port ex_pred_target  input  32  fetch-stage predicted target; meaningful only if ex_pred_taken=1.
REQ-012 SHALL have port redirect_valid  output  1  corrected fetch PC offered to fetch.
REQ-013 SHALL have port redirect_pc  output  32  corrected fetch PC.
REQ-014 SHALL have port redirect_ready  input  1  fetch accepts redirect_pc this cycle.
REQ-015 SHALL have port flush  output  1  squash IF/ID contents.
REQ-016 SHALL have port stall_ex  output  1  hold EX and earlier stages.

Function
REQ-017 Actual outcome: taken = ex_is_branch ? ex_cond_true : 1; actual target = ex_is_branch ? ex_pc + ex_imm (32-bit wrap) : ex_jump_target with bit0 cleared.
REQ-018 Mispredict = (taken != ex_pred_taken) OR (taken AND ex_pred_taken AND actual target != ex_pred_target).
REQ-019 Correct PC = taken ? actual target : ex_pc + 4 (32-bit wrap).
REQ-020 FSM states IDLE, REDIRECT, FLUSH; all outputs registered.
REQ-021 IDLE: ex_valid AND mispredict -> capture correct PC into redirect_pc, go REDIRECT; correct prediction or ex_valid=0 -> stay IDLE, no output change.
REQ-022 REDIRECT: redirect_valid=1, flush=1, stall_ex=1; redirect_pc SHALL stay stable until handshake.
REQ-023 REDIRECT with redirect_ready=1 -> handshake completes that cycle; next state FLUSH with counter = FLUSH_CYCLES, or IDLE if FLUSH_CYCLES=0.
REQ-024 FLUSH: redirect_valid=0, stall_ex=0, flush=1; counter decrements each cycle; counter reaching 1 -> IDLE next cycle.
REQ-025 ex_valid SHALL be ignored in REDIRECT and FLUSH (instruction is wrong-path).
REQ-026 Latency: mispredict seen on cycle N -> redirect_valid=1 on cycle N+1.
REQ-027 redirect_ready while in IDLE or FLUSH SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, redirect_valid=0, redirect_pc=0, flush=0, stall_ex=0, counter=0, regardless of clk.
REQ-029 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abandon the pending redirect; no redirect is issued after rst deasserts.

Configuration
REQ-030 Macro BR_RESOLVER_STATS_EN defined: SHALL add outputs stat_branches (32) and stat_mispredicts (32); stat_branches increments on each accepted ex_valid in IDLE, stat_mispredicts on each entry to REDIRECT; both wrap modulo 2^32 and reset to 0.
REQ-031 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 ex_pc=0x1000, branch, imm=-32, pred_taken=1, pred_target=0x0FE0, cond_true=1 -> no redirect, flush=0 throughout.
REQ-033 Same as REQ-032 but cond_true=0 -> next cycle redirect_valid=1, redirect_pc=0x1004, stall_ex=1, flush=1.
REQ-034 ex_pc=0x1000, branch, imm=+16, pred_taken=0, cond_true=1 -> redirect_pc=0x1010; redirect_ready=1 first cycle -> flush high exactly 2 further cycles, then IDLE.
REQ-035 Jump, ex_jump_target=0x2001, pred_taken=1, pred_target=0x3000 -> redirect_pc=0x2000; redirect_ready held low 3 cycles -> redirect_valid and redirect_pc=0x2000 stable all 3 cycles; ex_valid mispredicts during REDIRECT/FLUSH ignored.
REQ-036 rst pulsed while in REDIRECT -> outputs zero in same cycle, no redirect afterwards; with BR_RESOLVER_STATS_EN, 3 branches incl. 1 mispredict -> stat_branches=3, stat_mispredicts=1.
